// File: rtl/dm_stall_if.sv
// Handshake bundle between the M-stage pipeline and the data-memory stall controller.
interface dm_stall_if;
    logic is_load;
    logic is_store;
    logic uncached;
    logic o_p_stall;
    logic data_sram_data_ok;
    logic read;
    logic write;
    logic dm_stall;

    modport master (
        output is_load, is_store, uncached, o_p_stall, data_sram_data_ok,
        input  read, write, dm_stall
    );

    modport slave (
        input  is_load, is_store, uncached, o_p_stall, data_sram_data_ok,
        output read, write, dm_stall
    );
endinterface

// File: rtl/dm_stall.sv
// Data-memory request/stall controller plus combinational load alignment and
// per-byte register write-enable generation.
module dm_stall (
    input  logic             clk,
    input  logic             Clr,
    dm_stall_if.slave        bus,
    input  logic [31:0]      RawMemData,
    input  logic [1:0]       Offset,
    input  logic [8:0]       ExtType,
    input  logic             M_WriteRegEnable,
    output logic [31:0]      ExtMemData,
    output logic [3:0]       M_WriteRegEnableExted
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t state;
    logic   mem;

    assign mem = bus.is_load | bus.is_store;

    always_ff @(posedge clk) begin
        if (Clr) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (mem && bus.uncached) state <= WAIT;
                WAIT:    if (bus.data_sram_data_ok) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes are Mealy outputs: the uncached request is issued once, in the IDLE cycle.
    always_comb begin
        bus.read     = 1'b0;
        bus.write    = 1'b0;
        bus.dm_stall = 1'b0;
        case (state)
            IDLE: begin
                if (mem) begin
                    bus.read     = bus.is_load;
                    bus.write    = bus.is_store;
                    bus.dm_stall = bus.uncached ? 1'b1 : bus.o_p_stall;
                end
            end
            WAIT: bus.dm_stall = !bus.data_sram_data_ok;
            default: ;
        endcase
    end

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] ext;
    logic [3:0]  en;

    // ExtType bit order: {lb, lbu, lh, lhu, lw, lwl, lwr, swl, swr}.
    always_comb begin
        byte_sel = RawMemData[{Offset, 3'b000} +: 8];
        half_sel = Offset[1] ? RawMemData[31:16] : RawMemData[15:0];
        ext      = RawMemData;
        en       = 4'b1111;
        if (ExtType[8]) begin
            ext = {{24{byte_sel[7]}}, byte_sel};
        end else if (ExtType[7]) begin
            ext = {24'h000000, byte_sel};
        end else if (ExtType[6]) begin
            ext = {{16{half_sel[15]}}, half_sel};
        end else if (ExtType[5]) begin
            ext = {16'h0000, half_sel};
        end else if (ExtType[3]) begin
            // 3 - Offset in two bits is simply ~Offset.
            ext = RawMemData << {~Offset, 3'b000};
            en  = 4'b1111 << ~Offset;
        end else if (ExtType[2]) begin
            ext = RawMemData >> {Offset, 3'b000};
            en  = 4'b1111 >> Offset;
        end
        ExtMemData            = ext;
        M_WriteRegEnableExted = M_WriteRegEnable ? en : 4'b0000;
    end

endmodule

// File: tb/tb_dm_stall.sv
// Scoreboard bench for dm_stall: expectations are queued as stimulus is applied
// and compared when the outputs settle on the falling edge.
module tb_dm_stall;

    localparam logic [8:0] T_LB  = 9'h100;
    localparam logic [8:0] T_LBU = 9'h080;
    localparam logic [8:0] T_LH  = 9'h040;
    localparam logic [8:0] T_LHU = 9'h020;
    localparam logic [8:0] T_LW  = 9'h010;
    localparam logic [8:0] T_LWL = 9'h008;
    localparam logic [8:0] T_LWR = 9'h004;
    localparam logic [8:0] T_SWL = 9'h002;
    localparam logic [8:0] T_SWR = 9'h001;

    logic        clk;
    logic        Clr;
    logic [31:0] RawMemData;
    logic [1:0]  Offset;
    logic [8:0]  ExtType;
    logic        M_WriteRegEnable;
    logic [31:0] ExtMemData;
    logic [3:0]  M_WriteRegEnableExted;

    dm_stall_if bus ();

    dm_stall dut (
        .clk                   (clk),
        .Clr                   (Clr),
        .bus                   (bus),
        .RawMemData            (RawMemData),
        .Offset                (Offset),
        .ExtType               (ExtType),
        .M_WriteRegEnable      (M_WriteRegEnable),
        .ExtMemData            (ExtMemData),
        .M_WriteRegEnableExted (M_WriteRegEnableExted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       tag;
        int          kind;
        logic [31:0] exp;
    } sb_t;

    sb_t sb[$];
    int  vectors     = 0;
    int  miscompares = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] observe(input int kind);
        case (kind)
            0:       return {31'b0, bus.read};
            1:       return {31'b0, bus.write};
            2:       return {31'b0, bus.dm_stall};
            3:       return ExtMemData;
            default: return {28'b0, M_WriteRegEnableExted};
        endcase
    endfunction

    task automatic push(input string tag, input int kind, input logic [31:0] v);
        sb_t e;
        e.tag  = tag;
        e.kind = kind;
        e.exp  = v;
        sb.push_back(e);
    endtask

    task automatic exp_ctl(input string t, input logic r, input logic w, input logic s);
        push({t, "_rd"}, 0, {31'b0, r});
        push({t, "_wr"}, 1, {31'b0, w});
        push({t, "_stall"}, 2, {31'b0, s});
    endtask

    task automatic exp_ext(input string t, input logic [31:0] d, input logic [3:0] e);
        push({t, "_data"}, 3, d);
        push({t, "_en"}, 4, {28'b0, e});
    endtask

    task automatic set_ctl(input logic ld, input logic st, input logic unc,
                           input logic ops, input logic dok);
        bus.is_load           = ld;
        bus.is_store          = st;
        bus.uncached          = unc;
        bus.o_p_stall         = ops;
        bus.data_sram_data_ok = dok;
    endtask

    // Settle, drain the scoreboard against the DUT, then advance one clock.
    task automatic tick();
        sb_t e;
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check_eq(e.tag, observe(e.kind), e.exp);
        end
        @(posedge clk);
        #1;
    endtask

    // Byte-wise reference for the extension path.
    task automatic ext_model(input logic [31:0] raw, input logic [1:0] off, input logic [8:0] typ,
                             input logic we, output logic [31:0] d, output logic [3:0] e);
        logic [7:0] b [4];
        logic [7:0] lo, hi;
        int         o;
        for (int i = 0; i < 4; i++) b[i] = raw[8*i +: 8];
        o  = int'(off);
        lo = b[2*(o/2)];
        hi = b[2*(o/2)+1];
        d  = raw;
        e  = 4'b1111;
        if (typ == T_LB)       d = {{24{b[o][7]}}, b[o]};
        else if (typ == T_LBU) d = {24'h0, b[o]};
        else if (typ == T_LH)  d = {{16{hi[7]}}, hi, lo};
        else if (typ == T_LHU) d = {16'h0, hi, lo};
        else if (typ == T_LWL) begin
            for (int j = 0; j < 4; j++) begin
                d[8*j +: 8] = (j >= 3 - o) ? b[j - (3 - o)] : 8'h00;
                e[j]        = (j >= 3 - o);
            end
        end else if (typ == T_LWR) begin
            for (int j = 0; j < 4; j++) begin
                d[8*j +: 8] = (j + o <= 3) ? b[j + o] : 8'h00;
                e[j]        = (j + o <= 3);
            end
        end
        if (!we) e = 4'b0000;
    endtask

    task automatic set_ext(input logic [31:0] raw, input logic [1:0] off,
                           input logic [8:0] typ, input logic we);
        RawMemData       = raw;
        Offset           = off;
        ExtType          = typ;
        M_WriteRegEnable = we;
    endtask

    logic [31:0] md;
    logic [3:0]  me;
    logic [8:0]  rt;
    int unsigned k;

    initial begin
        set_ctl(0, 0, 0, 0, 0);
        set_ext('0, '0, '0, 1'b1);
        Clr = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        Clr = 1'b0;

        // Reset state: quiet, and a hit-load proves IDLE.
        exp_ctl("rst_quiet", 0, 0, 0);
        tick();
        set_ctl(1, 0, 0, 0, 0);
        exp_ctl("rst_idle", 1, 0, 0);
        tick();

        // Cached lw with three miss cycles.
        for (int c = 0; c < 4; c++) begin
            set_ctl(1, 0, 0, c < 3, 0);
            exp_ctl($sformatf("cached_lw_c%0d", c), 1, 0, c < 3);
            tick();
        end
        set_ctl(1, 0, 0, 0, 0);
        exp_ctl("cached_lw_idle", 1, 0, 0);
        tick();

        // Uncached lw, data_ok on the 4th cycle.
        set_ctl(1, 0, 1, 0, 0);
        exp_ctl("unc_lw_c0", 1, 0, 1);
        tick();
        for (int c = 1; c < 3; c++) begin
            set_ctl(1, 0, 1, 0, 0);
            exp_ctl($sformatf("unc_lw_c%0d", c), 0, 0, 1);
            tick();
        end
        set_ctl(1, 0, 1, 0, 1);
        exp_ctl("unc_lw_c3", 0, 0, 0);
        tick();
        set_ctl(1, 0, 0, 0, 0);
        exp_ctl("unc_lw_back_idle", 1, 0, 0);
        tick();

        // data_ok while IDLE is ignored.
        set_ctl(0, 0, 0, 0, 1);
        exp_ctl("idle_dok", 0, 0, 0);
        tick();
        set_ctl(0, 1, 0, 0, 0);
        exp_ctl("idle_dok_after", 0, 1, 0);
        tick();

        // Uncached sw abandoned by Clr mid-WAIT.
        set_ctl(0, 1, 1, 0, 0);
        exp_ctl("unc_sw_c0", 0, 1, 1);
        tick();
        set_ctl(0, 1, 1, 0, 0);
        exp_ctl("unc_sw_c1", 0, 0, 1);
        tick();
        Clr = 1'b1;
        exp_ctl("unc_sw_clr", 0, 0, 1);
        tick();
        Clr = 1'b0;
        set_ctl(0, 0, 0, 0, 1);
        exp_ctl("unc_sw_late_dok", 0, 0, 0);
        tick();
        set_ctl(0, 1, 0, 0, 0);
        exp_ctl("unc_sw_idle", 0, 1, 0);
        tick();

        // Both strobes when load and store collide.
        set_ctl(1, 1, 0, 1, 0);
        exp_ctl("both", 1, 1, 1);
        tick();
        set_ctl(0, 0, 0, 0, 0);

        // Directed extension vectors.
        set_ext(32'h80FF7F01, 2'd1, T_LB, 1'b1);  exp_ext("lb_o1", 32'h0000007F, 4'b1111); tick();
        set_ext(32'h80FF7F01, 2'd3, T_LB, 1'b1);  exp_ext("lb_o3", 32'hFFFFFF80, 4'b1111); tick();
        set_ext(32'h80FF7F01, 2'd3, T_LBU, 1'b1); exp_ext("lbu_o3", 32'h00000080, 4'b1111); tick();
        set_ext(32'h80FF7F01, 2'd2, T_LHU, 1'b1); exp_ext("lhu_o2", 32'h000080FF, 4'b1111); tick();
        set_ext(32'h80FF7F01, 2'd2, T_LH, 1'b1);  exp_ext("lh_o2", 32'hFFFF80FF, 4'b1111); tick();
        set_ext(32'h80FF7F01, 2'd0, T_LH, 1'b1);  exp_ext("lh_o0", 32'h00007F01, 4'b1111); tick();
        set_ext(32'h11223344, 2'd1, T_LWL, 1'b1); exp_ext("lwl_o1", 32'h33440000, 4'b1100); tick();
        set_ext(32'h11223344, 2'd0, T_LWL, 1'b1); exp_ext("lwl_o0", 32'h44000000, 4'b1000); tick();
        set_ext(32'h11223344, 2'd3, T_LWL, 1'b1); exp_ext("lwl_o3", 32'h11223344, 4'b1111); tick();
        set_ext(32'h11223344, 2'd1, T_LWR, 1'b1); exp_ext("lwr_o1", 32'h00112233, 4'b0111); tick();
        set_ext(32'h11223344, 2'd3, T_LWR, 1'b1); exp_ext("lwr_o3", 32'h00000011, 4'b0001); tick();
        set_ext(32'h11223344, 2'd1, T_LWL, 1'b0); exp_ext("lwl_nowe", 32'h33440000, 4'b0000); tick();
        set_ext(32'h11223344, 2'd2, T_LW, 1'b1);  exp_ext("lw", 32'h11223344, 4'b1111); tick();
        set_ext(32'h11223344, 2'd2, T_SWL, 1'b1); exp_ext("swl", 32'h11223344, 4'b1111); tick();
        set_ext(32'h11223344, 2'd1, T_SWR, 1'b1); exp_ext("swr", 32'h11223344, 4'b1111); tick();
        set_ext(32'h11223344, 2'd1, 9'h000, 1'b1); exp_ext("none", 32'h11223344, 4'b1111); tick();

        // Random extension vectors against the byte-wise model.
        for (int i = 0; i < 24; i++) begin
            k  = $urandom_range(0, 9);
            rt = (k == 9) ? 9'h000 : (9'h001 << k);
            set_ext($urandom, 2'($urandom_range(0, 3)), rt, 1'($urandom_range(0, 3) != 0));
            ext_model(RawMemData, Offset, ExtType, M_WriteRegEnable, md, me);
            exp_ext($sformatf("rnd%0d_t%03h_o%0d", i, ExtType, Offset), md, me);
            tick();
        end

        if (sb.size() != 0) begin
            check_eq("sb_drained", 32'(sb.size()), 32'd0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dm_stall.md
DM_STALL -- requirements
Module: dm_stall

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 Clr  in  1  reset, synchronous, active-high.
REQ-003 is_load  in  1  M-stage instruction is a load (lb/lbu/lh/lhu/lw/lwl/lwr), decoded upstream.
REQ-004 is_store  in  1  M-stage instruction is a store (sb/sh/sw/swl/swr), decoded upstream.
REQ-005 uncached  in  1  current access targets the uncached data port.
REQ-006 o_p_stall  in  1  cache not ready/miss for the current cached access (high = stall).
REQ-007 data_sram_data_ok  in  1  uncached port returns read data / write completion this cycle.
REQ-008 read  out  1  read request strobe.
REQ-009 write  out  1  write request strobe.
REQ-010 dm_stall  out  1  freeze upstream pipeline registers.
REQ-011 RawMemData  in  32  raw word from memory, W-stage register.
REQ-012 Offset  in  2  byte address bits [1:0] of the access.
REQ-013 ExtType  in  9  one-hot {lb,lbu,lh,lhu,lw,lwl,lwr,swl,swr}, bit 8 = lb.
REQ-014 M_WriteRegEnable  in  1  instruction writes the register file.
REQ-015 ExtMemData  out  32  extended/aligned load result.
REQ-016 M_WriteRegEnableExted  out  4  per-byte register-file write enables, bit i = byte i.

Function -- stall/request FSM
REQ-017 Two states, IDLE and WAIT; mem = is_load|is_store.
REQ-018 IDLE, mem=0: read=write=0, dm_stall=0, stay IDLE.
REQ-019 IDLE, mem=1, uncached=0: read=is_load, write=is_store, dm_stall=o_p_stall, stay IDLE; cache handles miss internally.
REQ-020 IDLE, mem=1, uncached=1: read=is_load, write=is_store for exactly this cycle, dm_stall=1, next WAIT.
REQ-021 WAIT: read=write=0 (no reissue); dm_stall=!data_sram_data_ok; data_sram_data_ok=1 -> next IDLE and dm_stall=0 in that same cycle so the pipeline captures the data.
REQ-022 data_sram_data_ok in IDLE is ignored.
REQ-023 Minimum uncached latency: 2 cycles (request cycle + data_ok cycle); no upper bound, WAIT held indefinitely.
REQ-024 read, write, dm_stall are combinational from state and inputs; only the state is registered.
REQ-025 is_load and is_store never both 1; if both are 1, both strobes assert, no further handling.

Function -- load extension (combinational)
REQ-026 Byte sel = RawMemData[8*Offset+7:8*Offset]; half sel = RawMemData[16*Offset[1]+15:16*Offset[1]].
REQ-027 lb: sign-extend byte; lbu: zero-extend byte; lh: sign-extend half; lhu: zero-extend half; enables 1111.
REQ-028 lw: RawMemData unchanged; enables 1111.
REQ-029 lwl: ExtMemData = RawMemData << 8*(3-Offset); enables Offset 0:1000, 1:1100, 2:1110, 3:1111.
REQ-030 lwr: ExtMemData = RawMemData >> 8*Offset (logical); enables Offset 0:1111, 1:0111, 2:0011, 3:0001.
REQ-031 swl, swr or ExtType=0: ExtMemData = RawMemData; enables 1111.
REQ-032 M_WriteRegEnable=0 forces M_WriteRegEnableExted=0000 regardless of ExtType.
REQ-033 Offset misalignment for lh/lhu/lw is not checked.

Reset
REQ-034 Clr=1 at a clock edge -> state IDLE, overriding all other transitions, including mid-WAIT; any later data_ok for the abandoned access is ignored per REQ-022.
REQ-035 Extension path has no state and is unaffected by Clr.

Verification
REQ-036 Cached lw, o_p_stall=1 for 3 cycles then 0 -> read=1 for 4 cycles, dm_stall=1,1,1,0, state stays IDLE.
REQ-037 Uncached lw, data_ok on 4th cycle -> read=1 only in cycle 1, dm_stall=1,1,1,0, then IDLE.
REQ-038 Uncached sw, Clr asserted in WAIT, then data_ok -> write pulse once, after Clr dm_stall=0 and the data_ok is ignored.
REQ-039 Raw=0x80FF7F01: lb Off=1 -> 0x0000007F; lb Off=3 -> 0xFFFFFF80; lhu Off=2 -> 0x000080FF; lh Off=2 -> 0xFFFF80FF.
REQ-040 Raw=0x11223344: lwl Off=1 -> 0x33440000, en 1100; lwr Off=1 -> 0x00112233, en 0111; M_WriteRegEnable=0 -> en 0000.
